mem_fifo: RTL and testbench



---
 rtl/mem_fifo_pkg.sv | 37 +++
 rtl/mem_fifo_if.sv | 15 +
 rtl/mem_fifo_sync.sv | 28 ++
 rtl/mem_fifo.sv | 192 +++++++++++++++++++
 tb/tb_mem_fifo.sv | 607 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_fifo_pkg.sv
// mem_fifo_pkg: shared types and configuration helpers for mem_fifo.
//   enc_e        - handshake encoding (two-phase / four-phase)
//   in_state_e   - input-side handshake state
//   out_state_e  - output-side handshake state
//   decode_enc   - maps the ENC string parameter onto enc_e
//   cfg_legal    - true when an ENC/DEPTH/SYNC combination can be built
package mem_fifo_pkg;

   typedef enum logic {
      ENC_TP,
      ENC_FP
   } enc_e;

   typedef enum logic {
      IN_IDLE,
      IN_RTZ
   } in_state_e;

   typedef enum logic [1:0] {
      OUT_IDLE,
      OUT_SETUP,
      OUT_WAIT,
      OUT_RTZ
   } out_state_e;

   function automatic enc_e decode_enc(input string enc);
      return (enc == "FP") ? ENC_FP : ENC_TP;
   endfunction

   // DEPTH must be a power of two so the pointers wrap for free.
   function automatic bit cfg_legal(input string enc, input int depth, input int sync);
      return ((enc == "TP") || (enc == "FP")) &&
             (depth >= 2) && ((depth & (depth - 1)) == 0) &&
             (sync >= 2);
   endfunction

endpackage

// File: rtl/mem_fifo_if.sv
// mem_fifo_if: one bundled-data req/ack link.
//   req  - request, driven by the token sender
//   data - token, driven by the token sender, stable around each req event
//   ack  - acknowledge, driven by the token receiver
// master = token sender, slave = token receiver.
interface mem_fifo_if #(
   parameter int WIDTH = 1
);
   logic             req;
   logic             ack;
   logic [WIDTH-1:0] data;

   modport master (output req, output data, input ack);
   modport slave  (input req, input data, output ack);
endinterface

// File: rtl/mem_fifo_sync.sv
// sync_bit: SYNC-stage flop chain bringing an asynchronous level into the
// clk domain.
//   clk - destination clock
//   rst - asynchronous active-low reset, clears every stage
//   d   - asynchronous input
//   q   - synchronised output, SYNC rising edges behind d
module sync_bit #(
   parameter int SYNC = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC-1:0] stage;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage <= '0;
      end else begin
         stage <= {stage[SYNC-2:0], d};
      end
   end

   assign q = stage[SYNC-1];

endmodule

// File: rtl/mem_fifo.sv
// mem_fifo: DEPTH x WIDTH FIFO between two self-timed req/ack links.
// Both links use two-phase (ENC="TP") or four-phase (ENC="FP") signalling.
//   clk      - sole clock, all state on the rising edge
//   rst      - asynchronous active-low reset (memory contents are kept)
//   in_link  - incoming token link (req/data in, ack out)
//   out_link - outgoing token link (req/data out, ack in)
//   count    - occupancy, full/empty derived from it
module mem_fifo
   import mem_fifo_pkg::*;
#(
   parameter string ENC   = "TP",
   parameter int    WIDTH = 1,
   parameter int    DEPTH = 4,
   parameter int    SYNC  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   mem_fifo_if.slave                  in_link,
   mem_fifo_if.master                 out_link,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int   PW   = $clog2(DEPTH);
   localparam int   CW   = $clog2(DEPTH + 1);
   localparam enc_e MODE = decode_enc(ENC);

   if (!cfg_legal(ENC, DEPTH, SYNC)) begin : g_bad_cfg
      $error("mem_fifo: ENC must be TP or FP, DEPTH a power of two >= 2, SYNC >= 2");
   end

   logic             req_s;
   logic             ack_s;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [CW-1:0]    count_nxt;

   in_state_e        in_state;
   in_state_e        in_state_nxt;
   logic             in_ack_q;
   logic             in_ack_nxt;
   logic             wr_en;

   out_state_e       out_state;
   out_state_e       out_state_nxt;
   logic             out_req_q;
   logic             out_req_nxt;
   logic [WIDTH-1:0] out_data_q;
   logic             load_en;
   logic             pop_en;

   sync_bit #(.SYNC(SYNC)) u_sync_req (
      .clk (clk),
      .rst (rst),
      .d   (in_link.req),
      .q   (req_s)
   );

   sync_bit #(.SYNC(SYNC)) u_sync_ack (
      .clk (clk),
      .rst (rst),
      .d   (out_link.ack),
      .q   (ack_s)
   );

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Input side. In two-phase mode a token is pending whenever req_s and
   // in_ack disagree; the state variable stays in IN_IDLE. While full the
   // token simply stays pending, which stalls the sender.
   always_comb begin
      in_state_nxt = in_state;
      in_ack_nxt   = in_ack_q;
      wr_en        = 1'b0;
      if (MODE == ENC_TP) begin
         if ((req_s != in_ack_q) && !full) begin
            wr_en      = 1'b1;
            in_ack_nxt = ~in_ack_q;
         end
      end else begin
         case (in_state)
            IN_IDLE: begin
               if (req_s && !full) begin
                  wr_en        = 1'b1;
                  in_ack_nxt   = 1'b1;
                  in_state_nxt = IN_RTZ;
               end
            end
            IN_RTZ: begin
               if (!req_s) begin
                  in_ack_nxt   = 1'b0;
                  in_state_nxt = IN_IDLE;
               end
            end
            default: in_state_nxt = IN_IDLE;
         endcase
      end
   end

   // Output side. OUT_SETUP exists so out_data is stable for a full cycle
   // before the req event reaches the receiver. The entry is popped only
   // when the receiver acknowledges, so a token on the link still counts.
   always_comb begin
      out_state_nxt = out_state;
      out_req_nxt   = out_req_q;
      load_en       = 1'b0;
      pop_en        = 1'b0;
      case (out_state)
         OUT_IDLE: begin
            if (!empty) begin
               load_en       = 1'b1;
               out_state_nxt = OUT_SETUP;
            end
         end
         OUT_SETUP: begin
            out_req_nxt   = (MODE == ENC_TP) ? ~out_req_q : 1'b1;
            out_state_nxt = OUT_WAIT;
         end
         OUT_WAIT: begin
            if (MODE == ENC_TP) begin
               if (ack_s == out_req_q) begin
                  pop_en        = 1'b1;
                  out_state_nxt = OUT_IDLE;
               end
            end else if (ack_s) begin
               pop_en        = 1'b1;
               out_req_nxt   = 1'b0;
               out_state_nxt = OUT_RTZ;
            end
         end
         OUT_RTZ: begin
            if (!ack_s) begin
               out_state_nxt = OUT_IDLE;
            end
         end
         default: out_state_nxt = OUT_IDLE;
      endcase
   end

   // A write and a pop in the same cycle cancel out.
   always_comb begin
      count_nxt = count;
      if (wr_en && !pop_en) begin
         count_nxt = count + CW'(1);
      end else if (!wr_en && pop_en) begin
         count_nxt = count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_state   <= IN_IDLE;
         in_ack_q   <= 1'b0;
         out_state  <= OUT_IDLE;
         out_req_q  <= 1'b0;
         out_data_q <= '0;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
      end else begin
         in_state  <= in_state_nxt;
         in_ack_q  <= in_ack_nxt;
         out_state <= out_state_nxt;
         out_req_q <= out_req_nxt;
         count     <= count_nxt;
         if (wr_en) begin
            wptr <= wptr + PW'(1);
         end
         if (pop_en) begin
            rptr <= rptr + PW'(1);
         end
         if (load_en) begin
            out_data_q <= mem[rptr];
         end
      end
   end

   // Storage is not reset; entries are only read after being written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wptr] <= in_link.data;
      end
   end

   assign in_link.ack   = in_ack_q;
   assign out_link.req  = out_req_q;
   assign out_link.data = out_data_q;

endmodule

// File: tb/tb_mem_fifo.sv
// tb_mem_fifo: self-checking bench for mem_fifo.
// Two instances: u_tp (two-phase, WIDTH=8) and u_fp (four-phase, WIDTH=4),
// both DEPTH=4, SYNC=2, sharing clk and rst. Link partners are modelled as
// processes; expected token streams are kept in queues.
module tb_mem_fifo;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] tp_count;
   logic       tp_full;
   logic       tp_empty;
   logic [2:0] fp_count;
   logic       fp_full;
   logic       fp_empty;

   int errors = 0;
   int checks = 0;

   mem_fifo_if #(.WIDTH(8)) tp_in ();
   mem_fifo_if #(.WIDTH(8)) tp_out ();
   mem_fifo_if #(.WIDTH(4)) fp_in ();
   mem_fifo_if #(.WIDTH(4)) fp_out ();

   mem_fifo #(.ENC("TP"), .WIDTH(8), .DEPTH(4), .SYNC(SYNC)) u_tp (
      .clk      (clk),
      .rst      (rst),
      .in_link  (tp_in.slave),
      .out_link (tp_out.master),
      .count    (tp_count),
      .full     (tp_full),
      .empty    (tp_empty)
   );

   mem_fifo #(.ENC("FP"), .WIDTH(4), .DEPTH(4), .SYNC(SYNC)) u_fp (
      .clk      (clk),
      .rst      (rst),
      .in_link  (fp_in.slave),
      .out_link (fp_out.master),
      .count    (fp_count),
      .full     (fp_full),
      .empty    (fp_empty)
   );

   always #5 clk = ~clk;

   // Consumer/monitor state (each variable written by one process only).
   int         tp_ack_limit = 1 << 30;
   int         tp_ack_delay = 3;
   bit         tp_ack_rand  = 1'b0;
   int         tp_kick_req  = 0;
   int         tp_acks_done = 0;
   logic [7:0] tp_rx[$];
   int         tp_setup_bad = 0;
   logic [3:0] fp_rx[$];
   int         fp_rise = 0;
   int         fp_fall = 0;
   int         fp_setup_bad = 0;

   // Main-thread state.
   logic [7:0] tp_model[$];
   int         tp_base = 0;
   int         tp_peak = 0;

   // Two-phase receiver: acknowledges each req event after a delay, as long
   // as the ack limit allows; a kick forces one immediate ack toggle.
   initial begin : tp_consumer
      int wait_n;
      int kick_done;
      int lim;
      wait_n    = 0;
      kick_done = 0;
      lim       = 3;
      tp_out.ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst) begin
            tp_out.ack = 1'b0;
            wait_n     = 0;
         end else if (tp_kick_req != kick_done) begin
            tp_out.ack = ~tp_out.ack;
            kick_done  = tp_kick_req;
         end else if ((tp_out.req != tp_out.ack) && (tp_acks_done < tp_ack_limit)) begin
            if (!tp_ack_rand) lim = tp_ack_delay;
            if (wait_n >= lim) begin
               tp_out.ack = tp_out.req;
               tp_acks_done++;
               wait_n = 0;
               lim    = $urandom_range(0, 5);
            end else begin
               wait_n++;
            end
         end
      end
   end

   initial begin : tp_monitor
      logic       last_req;
      logic [7:0] prev_data;
      last_req  = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            last_req  = 1'b0;
            prev_data = '0;
         end else begin
            if (tp_out.req !== last_req) begin
               tp_rx.push_back(tp_out.data);
               if (tp_out.data !== prev_data) tp_setup_bad++;
               last_req = tp_out.req;
            end
            prev_data = tp_out.data;
         end
      end
   end

   // Four-phase receiver: raises ack 3 cycles after req rises, drops it 3
   // cycles after req falls.
   initial begin : fp_consumer
      int n;
      n = 0;
      fp_out.ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst) begin
            fp_out.ack = 1'b0;
            n          = 0;
         end else if (fp_out.req != fp_out.ack) begin
            if (n >= 3) begin
               fp_out.ack = fp_out.req;
               n          = 0;
            end else begin
               n++;
            end
         end
      end
   end

   initial begin : fp_monitor
      logic       last_req;
      logic [3:0] prev_data;
      last_req  = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            last_req  = 1'b0;
            prev_data = '0;
         end else begin
            if (fp_out.req && !last_req) begin
               fp_rx.push_back(fp_out.data);
               fp_rise++;
               if (fp_out.data !== prev_data) fp_setup_bad++;
            end
            if (!fp_out.req && last_req) fp_fall++;
            last_req  = fp_out.req;
            prev_data = fp_out.data;
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation still running, limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tp_offer(input logic [7:0] v);
      @(posedge clk);
      #2;
      tp_in.data = v;
      tp_in.req  = ~tp_in.req;
   endtask

   task automatic tp_wait_in_ack(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (int'(tp_count) > tp_peak) tp_peak = int'(tp_count);
         if (tp_in.ack == tp_in.req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic tp_drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (int'(tp_count) > tp_peak) tp_peak = int'(tp_count);
         if ((tp_rx.size() - tp_base) == tp_model.size() && tp_count == 3'd0 &&
             tp_out.req == tp_out.ack) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic tp_start(input int limit, input int delay, input bit rnd);
      tp_model.delete();
      tp_base      = tp_rx.size();
      tp_peak      = 0;
      tp_ack_limit = limit;
      tp_ack_delay = delay;
      tp_ack_rand  = rnd;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst        = 1'b0;
      tp_in.req  = 1'b0;
      tp_in.data = '0;
      fp_in.req  = 1'b0;
      fp_in.data = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tp_in.ack, tp_out.req, tp_out.data, tp_count, tp_empty, tp_full} !==
          {1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_tp: ack/req/data/count/empty/full got %b %b %h %0d %b %b want 0 0 00 0 1 0",
                  tp_in.ack, tp_out.req, tp_out.data, tp_count, tp_empty, tp_full);
      end
      checks++;
      if ({fp_in.ack, fp_out.req, fp_out.data, fp_count, fp_empty, fp_full} !==
          {1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_fp: ack/req/data/count/empty/full got %b %b %h %0d %b %b want 0 0 0 0 1 0",
                  fp_in.ack, fp_out.req, fp_out.data, fp_count, fp_empty, fp_full);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_loopback();
      logic [7:0] vals[3];
      bit ok;
      vals = '{8'h11, 8'h22, 8'h33};
      tp_start(1 << 30, 3, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tp_offer(vals[k]);
         tp_wait_in_ack(40, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL loop_in_ack[%0d]: in_ack=%b required=%b", k, tp_in.ack, tp_in.req);
         end else tp_model.push_back(vals[k]);
      end
      tp_drain(300, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL loop_drain: got %0d tokens count=%0d want %0d tokens count=0",
                  tp_rx.size() - tp_base, tp_count, tp_model.size());
      end
      for (int i = 0; i < tp_model.size(); i++) begin
         checks++;
         if (tp_base + i >= tp_rx.size()) begin
            errors++;
            $display("FAIL loop_order[%0d]: no token want %h", i, tp_model[i]);
         end else if (tp_rx[tp_base + i] !== tp_model[i]) begin
            errors++;
            $display("FAIL loop_order[%0d]: got %h want %h", i, tp_rx[tp_base + i], tp_model[i]);
         end
      end
      checks++;
      if (tp_peak < 1 || tp_peak > 3) begin
         errors++;
         $display("FAIL loop_peak: count peak %0d want 1..3", tp_peak);
      end
      checks++;
      if (tp_empty !== 1'b1 || tp_count !== 3'd0) begin
         errors++;
         $display("FAIL loop_empty: empty=%b count=%0d want 1 0", tp_empty, tp_count);
      end
   endtask

   task automatic test_fill();
      bit ok;
      int setup0;
      setup0 = tp_setup_bad;
      tp_start(tp_acks_done, 0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tp_offer(8'hC0 + 8'(k));
         tp_wait_in_ack(40, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL fill_in_ack[%0d]: in_ack=%b required=%b", k, tp_in.ack, tp_in.req);
         end else tp_model.push_back(8'hC0 + 8'(k));
      end
      repeat (10) @(negedge clk);
      checks++;
      if (tp_count !== 3'd4 || tp_full !== 1'b1 || tp_empty !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: count=%0d full=%b empty=%b want 4 1 0", tp_count, tp_full, tp_empty);
      end
      tp_offer(8'hC4);
      repeat (20) @(negedge clk);
      checks++;
      if (tp_in.ack === tp_in.req || tp_count !== 3'd4) begin
         errors++;
         $display("FAIL fill_stall: in_ack=%b req=%b count=%0d want ack withheld, count 4",
                  tp_in.ack, tp_in.req, tp_count);
      end
      tp_ack_limit = tp_acks_done + 1;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tp_full === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL fill_release: full=%b want 0 after one ack", tp_full);
      end
      tp_wait_in_ack(SYNC + 2, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL fill_fifth: in_ack=%b required=%b within %0d cycles", tp_in.ack, tp_in.req, SYNC + 2);
      end else tp_model.push_back(8'hC4);
      tp_ack_limit = 1 << 30;
      tp_ack_delay = 3;
      tp_drain(400, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL fill_drain: got %0d tokens count=%0d want %0d tokens count=0",
                  tp_rx.size() - tp_base, tp_count, tp_model.size());
      end
      for (int i = 0; i < tp_model.size(); i++) begin
         checks++;
         if (tp_base + i >= tp_rx.size()) begin
            errors++;
            $display("FAIL fill_order[%0d]: no token want %h", i, tp_model[i]);
         end else if (tp_rx[tp_base + i] !== tp_model[i]) begin
            errors++;
            $display("FAIL fill_order[%0d]: got %h want %h", i, tp_rx[tp_base + i], tp_model[i]);
         end
      end
      checks++;
      if (tp_setup_bad != setup0) begin
         errors++;
         $display("FAIL tp_setup: %0d req events with data changing on the same cycle, want 0",
                  tp_setup_bad - setup0);
      end
   endtask

   task automatic test_fp();
      logic [3:0] fv[2];
      bit ok;
      int n;
      int base;
      int rise0;
      int fall0;
      int setup0;
      fv     = '{4'hA, 4'h5};
      base   = fp_rx.size();
      rise0  = fp_rise;
      fall0  = fp_fall;
      setup0 = fp_setup_bad;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #2;
         checks++;
         if (fp_in.ack !== 1'b0) begin
            errors++;
            $display("FAIL fp_ack_idle[%0d]: in_ack=%b want 0 before req rises", k, fp_in.ack);
         end
         fp_in.data = fv[k];
         fp_in.req  = 1'b1;
         ok = 1'b0;
         n  = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (fp_in.ack === 1'b1) begin
               ok = 1'b1;
               break;
            end
         end
         checks++;
         if (!ok || n < 2) begin
            errors++;
            $display("FAIL fp_ack_rise[%0d]: seen=%b after %0d cycles want 1 after >=2", k, ok, n);
         end
         @(posedge clk);
         #2;
         fp_in.req = 1'b0;
         ok = 1'b0;
         n  = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (fp_in.ack === 1'b0) begin
               ok = 1'b1;
               break;
            end
         end
         checks++;
         if (!ok || n < 2) begin
            errors++;
            $display("FAIL fp_ack_fall[%0d]: seen=%b after %0d cycles want 0 after >=2", k, ok, n);
         end
      end
      ok = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if ((fp_fall - fall0) == 2 && fp_count == 3'd0 && !fp_out.req && !fp_out.ack) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || (fp_rise - rise0) != 2 || (fp_fall - fall0) != 2) begin
         errors++;
         $display("FAIL fp_rtz: rises=%0d falls=%0d count=%0d want 2 2 0",
                  fp_rise - rise0, fp_fall - fall0, fp_count);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (base + i >= fp_rx.size()) begin
            errors++;
            $display("FAIL fp_data[%0d]: no token want %h", i, fv[i]);
         end else if (fp_rx[base + i] !== fv[i]) begin
            errors++;
            $display("FAIL fp_data[%0d]: got %h want %h", i, fp_rx[base + i], fv[i]);
         end
      end
      checks++;
      if (fp_setup_bad != setup0) begin
         errors++;
         $display("FAIL fp_setup: %0d req rises with data changing on the same cycle, want 0",
                  fp_setup_bad - setup0);
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      tp_start(tp_acks_done, 0, 1'b0);
      tp_offer(8'h5A);
      tp_wait_in_ack(40, ok);
      if (ok) tp_model.push_back(8'h5A);
      tp_offer(8'hA5);
      tp_wait_in_ack(40, ok);
      if (ok) tp_model.push_back(8'hA5);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (tp_count == 3'd2 && tp_out.req != tp_out.ack) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL simul_setup: count=%0d out_req=%b out_ack=%b want 2 with req pending",
                  tp_count, tp_out.req, tp_out.ack);
      end
      // ack and a new req land in the same cycle: one pop and one write
      @(negedge clk);
      tp_kick_req++;
      tp_offer(8'h3C);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (tp_count !== 3'd2 || tp_full !== 1'b0 || tp_empty !== 1'b0) begin
            errors++;
            $display("FAIL simul_count[%0d]: count=%0d full=%b empty=%b want 2 0 0",
                     i, tp_count, tp_full, tp_empty);
         end
      end
      checks++;
      if (tp_in.ack !== tp_in.req) begin
         errors++;
         $display("FAIL simul_accept: in_ack=%b want %b", tp_in.ack, tp_in.req);
      end else tp_model.push_back(8'h3C);
      tp_ack_limit = 1 << 30;
      tp_ack_delay = 2;
      tp_drain(300, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL simul_drain: got %0d tokens want %0d", tp_rx.size() - tp_base, tp_model.size());
      end
      for (int i = 0; i < tp_model.size(); i++) begin
         checks++;
         if (tp_base + i >= tp_rx.size() || tp_rx[tp_base + i] !== tp_model[i]) begin
            errors++;
            $display("FAIL simul_order[%0d]: got %h want %h", i,
                     (tp_base + i < tp_rx.size()) ? tp_rx[tp_base + i] : 8'hxx, tp_model[i]);
         end
      end
   endtask

   task automatic test_wrap();
      bit ok;
      tp_start(1 << 30, 0, 1'b1);
      for (int v = 0; v < 10; v++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         tp_offer(8'(v));
         tp_wait_in_ack(80, ok);
         if (ok) tp_model.push_back(8'(v));
         else begin
            checks++;
            errors++;
            $display("FAIL wrap_in_ack[%0d]: in_ack=%b required=%b", v, tp_in.ack, tp_in.req);
         end
      end
      tp_drain(600, ok);
      checks++;
      if (!ok || tp_model.size() != 10) begin
         errors++;
         $display("FAIL wrap_drain: got %0d tokens accepted %0d want 10 10",
                  tp_rx.size() - tp_base, tp_model.size());
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (tp_base + i >= tp_rx.size()) begin
            errors++;
            $display("FAIL wrap_order[%0d]: no token want %h", i, 8'(i));
         end else if (tp_rx[tp_base + i] !== 8'(i)) begin
            errors++;
            $display("FAIL wrap_order[%0d]: got %h want %h", i, tp_rx[tp_base + i], 8'(i));
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      tp_start(tp_acks_done, 0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tp_offer(8'h91 + 8'(k));
         tp_wait_in_ack(40, ok);
      end
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (tp_count == 3'd3 && tp_out.req != tp_out.ack) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rmid_setup: count=%0d out_req=%b out_ack=%b want 3 with req pending",
                  tp_count, tp_out.req, tp_out.ack);
      end
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if ({tp_in.ack, tp_out.req, tp_out.data, tp_count, tp_empty, tp_full} !==
          {1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL rmid_async: ack/req/data/count/empty/full got %b %b %h %0d %b %b want 0 0 00 0 1 0",
                  tp_in.ack, tp_out.req, tp_out.data, tp_count, tp_empty, tp_full);
      end
      tp_in.req = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      tp_start(1 << 30, 3, 1'b0);
      tp_offer(8'h7E);
      tp_wait_in_ack(40, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rmid_in_ack: in_ack=%b required=%b", tp_in.ack, tp_in.req);
      end else tp_model.push_back(8'h7E);
      tp_drain(200, ok);
      checks++;
      if (!ok || (tp_rx.size() - tp_base) != 1 || tp_rx[tp_base] !== 8'h7E) begin
         errors++;
         $display("FAIL rmid_token: got %0d tokens first=%h want 1 token 7e",
                  tp_rx.size() - tp_base, (tp_rx.size() > tp_base) ? tp_rx[tp_base] : 8'hxx);
      end
   endtask

   initial begin : main
      test_reset();
      test_loopback();
      test_fill();
      test_fp();
      test_simultaneous();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
